// File: rtl/cdbus_pkg.sv
// cdbus_pkg: shared state encodings and frame constants for the cdbus serializer.
package cdbus_pkg;
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        BITS  = 4'b0100,
        STOP  = 4'b1000
    } state_e;
    localparam int          BITS_PER_BYTE = 10;
    localparam int          CRC_BYTES     = 2;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY      = 16'hA001;
endpackage

// File: rtl/serial_crc.sv
// serial_crc: bit-serial reflected CRC-16, one LSB-first data bit per data_clk.
module serial_crc
    import cdbus_pkg::*;
(
    input  logic        clk,
    input  logic        clean,
    input  logic        data_clk,
    input  logic        data_in,
    output logic [15:0] crc_out
);
    always_ff @(posedge clk) begin
        if (clean) crc_out <= CRC_INIT;
        else if (data_clk) crc_out <= (crc_out >> 1) ^ ((crc_out[0] ^ data_in) ? CRC_POLY : 16'h0000);
    end
endmodule

// File: rtl/tx_ser.sv
// tx_ser: UART-style byte serializer sending payload plus CRC-16; first byte at low speed, rest at high speed.
module tx_ser
    import cdbus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] div_ls,
    input  logic [15:0] div_hs,
    input  logic        tx_permit,
    input  logic        abort,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        tx,
    output logic        tx_en,
    output logic        frame_done
);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, div_q, div_d, crc;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic [1:0]  crc_n_q, crc_n_d;
    logic        last_q, last_d, hs_q, hs_d, tx_q, tx_d, en_q, en_d, done_q, done_d;
    logic        bit_end, last_data, next_byte, clean, data_clk;

    assign bit_end   = cnt_q == div_q;
    assign last_data = state_q == BITS && bit_q == 4'(BITS_PER_BYTE - 2);
    assign tx         = tx_q;
    assign tx_en      = en_q;
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            crc_n_q <= '0;
            last_q  <= 1'b0;
            hs_q    <= 1'b0;
            tx_q    <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            crc_n_q <= crc_n_d;
            last_q  <= last_d;
            hs_q    <= hs_d;
            tx_q    <= tx_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    // crc_n_q: 0 while sending payload, 1 for the CRC low byte, 2 for the CRC high byte
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        crc_n_d   = crc_n_q;
        last_d    = last_q;
        hs_d      = hs_q;
        tx_d      = tx_q;
        en_d      = en_q;
        done_d    = 1'b0;
        next_byte = 1'b0;
        unique case (state_q)
            IDLE: if (s_valid && s_ready) begin
                next_byte = 1'b1;
                sh_d      = s_data;
                last_d    = s_last;
                crc_n_d   = 2'd0;
                hs_d      = 1'b0;
                en_d      = 1'b1;
            end
            START, BITS: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    state_d = last_data ? STOP : BITS;
                    tx_d    = last_data | sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = bit_q + 4'd1;
                    cnt_d   = '0;
                    div_d   = hs_q ? div_hs : div_ls;
                end
            end
            STOP: begin
                if (!bit_end) cnt_d = cnt_q + 16'd1;
                else if (crc_n_q == 2'(CRC_BYTES)) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end else if (crc_n_q != 2'd0 || last_q) begin
                    next_byte = 1'b1;
                    sh_d      = crc_n_q == 2'd0 ? crc[7:0] : crc[15:8];
                    crc_n_d   = crc_n_q + 2'd1;
                    hs_d      = 1'b1;
                end else if (s_valid) begin
                    next_byte = 1'b1;
                    sh_d      = s_data;
                    last_d    = s_last;
                    hs_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (next_byte) begin
            state_d = START;
            tx_d    = 1'b0;
            bit_d   = '0;
            cnt_d   = '0;
            div_d   = hs_d ? div_hs : div_ls;
        end
        if (abort) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            en_d    = 1'b0;
            done_d  = 1'b0;
            hs_d    = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            crc_n_d = 2'd0;
        end
    end

    always_comb begin
        s_ready  = !reset && !abort && (state_q == IDLE ? tx_permit : state_q == STOP && bit_end && crc_n_q == 2'd0 && !last_q);
        clean    = reset || (state_q == IDLE && s_valid && s_ready);
        data_clk = !abort && crc_n_q == 2'd0 && bit_end && (state_q == START || (state_q == BITS && !last_data));
    end

    serial_crc u_crc (
        .clk     (clk),
        .clean   (clean),
        .data_clk(data_clk),
        .data_in (sh_q[0]),
        .crc_out (crc)
    );
endmodule

// File: tb/tb_tx_ser.sv
// tb_tx_ser: directed frame scenarios against hand-built tx waveforms and a CRC-16 byte model.
module tb_tx_ser;
    logic        clk = 1'b0, reset = 1'b1, tx_permit = 1'b0, abort = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0;
    logic [15:0] div_ls = 16'd0, div_hs = 16'd0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, tx, tx_en, frame_done;
    int          checks = 0, failures = 0, hold = 0;

    typedef struct {logic last; logic [7:0] d; int dly;} ent_t;
    ent_t       src_q[$];
    logic [7:0] pay_q[$];
    logic       exp_q[$], log_tx[$], log_en[$], log_done[$], log_rdy[$];
    int         acc[$];

    always #5 clk = ~clk;

    tx_ser dut (
        .clk(clk), .reset(reset), .div_ls(div_ls), .div_hs(div_hs), .tx_permit(tx_permit),
        .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .tx(tx), .tx_en(tx_en), .frame_done(frame_done)
    );

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
        return r;
    endfunction

    function automatic logic lt(input int i);
        return i < log_tx.size() ? log_tx[i] : 1'bx;
    endfunction
    function automatic logic le(input int i);
        return i < log_en.size() ? log_en[i] : 1'bx;
    endfunction
    function automatic logic ld(input int i);
        return i < log_done.size() ? log_done[i] : 1'bx;
    endfunction

    function automatic int tx_diff(input int s, input int n);
        for (int i = 0; i < n; i++) if (lt(s + i) !== exp_q[i]) return i;
        return -1;
    endfunction
    function automatic int bad_en(input int s, input int n, input logic v);
        int c = 0;
        for (int i = s; i < s + n; i++) if (le(i) !== v) c++;
        return c;
    endfunction
    function automatic int count_done();
        int c = 0;
        foreach (log_done[i]) if (log_done[i] === 1'b1) c++;
        return c;
    endfunction

    // One clock of stimulus: present head byte, sample outputs mid-cycle, pop on handshake.
    task automatic step();
        logic fire;
        int   c;
        c = log_tx.size();
        if (hold == 0 && src_q.size() > 0) begin
            s_valid = 1'b1;
            s_last  = src_q[0].last;
            s_data  = src_q[0].d;
        end else s_valid = 1'b0;
        @(negedge clk);
        log_tx.push_back(tx);
        log_en.push_back(tx_en);
        log_done.push_back(frame_done);
        log_rdy.push_back(s_ready);
        fire = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hold > 0) hold--;
        if (fire) begin
            acc.push_back(c);
            void'(src_q.pop_front());
            if (src_q.size() > 0) hold = src_q[0].dly;
        end
    endtask

    task automatic add_byte(input logic [7:0] b, input int p);
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (p) exp_q.push_back(v);
        end
    endtask

    task automatic prep(input logic [15:0] ls, input logic [15:0] hs);
        logic [15:0] c;
        c = 16'hFFFF;
        div_ls = ls; div_hs = hs; tx_permit = 1'b1; abort = 1'b0; reset = 1'b0; hold = 0;
        log_tx.delete(); log_en.delete(); log_done.delete(); log_rdy.delete(); acc.delete();
        src_q.delete(); exp_q.delete();
        foreach (pay_q[i]) begin
            ent_t e;
            e.last = (i == pay_q.size() - 1);
            e.d    = pay_q[i];
            e.dly  = 0;
            src_q.push_back(e);
            add_byte(pay_q[i], i == 0 ? int'(ls) + 1 : int'(hs) + 1);
            c = crc_upd(c, pay_q[i]);
        end
        add_byte(c[7:0], int'(hs) + 1);
        add_byte(c[15:8], int'(hs) + 1);
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        do begin step(); n++; end while (!(log_done.size() > 0 && log_done[$] === 1'b1) && n < budget);
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_permit = 1'b1; s_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_prio_rdy: got %b want 0", s_ready); end
        @(posedge clk); #1;
        reset = 1'b0; tx_permit = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b want 0", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int a0, l, d, ix;
        logic [9:0] got;
        pay_q.delete(); pay_q.push_back(8'h01);
        prep(16'd9, 16'd3);
        run_done(600);
        a0 = acc.size() > 0 ? acc[0] : 0;
        l  = exp_q.size();
        checks++; if (acc.size() !== 1 || a0 !== 0) begin failures++; $display("FAIL single_accept: got n=%0d at %0d want n=1 at 0", acc.size(), a0); end
        for (int k = 0; k < 10; k++) got[k] = lt(a0 + 1 + 10 * k + 5);
        checks++; if (got !== 10'b1000000010) begin failures++; $display("FAIL single_bits: got %b want 1000000010", got); end
        d = tx_diff(a0 + 1, l);
        checks++; if (d != -1) begin failures++; $display("FAIL single_wave: cycle %0d got %b want %b", d, lt(a0 + 1 + d), exp_q[d]); end
        checks++; if (bad_en(a0 + 1, l, 1'b1) != 0) begin failures++; $display("FAIL single_en: got %0d low cycles want 0", bad_en(a0 + 1, l, 1'b1)); end
        ix = a0 + l + 1;
        checks++; if (ld(ix) !== 1'b1 || le(ix) !== 1'b0 || lt(ix) !== 1'b1) begin failures++; $display("FAIL single_end: got done=%b en=%b tx=%b want 1 0 1", ld(ix), le(ix), lt(ix)); end
        checks++; if (count_done() != 1) begin failures++; $display("FAIL single_pulse: got %0d done cycles want 1", count_done()); end
    endtask

    task automatic test_multi();
        int d, l;
        logic [15:0] c, got;
        pay_q.delete(); pay_q.push_back(8'hA5); pay_q.push_back(8'h3C); pay_q.push_back(8'hFF);
        prep(16'd9, 16'd1);
        run_done(600);
        l = exp_q.size();
        checks++; if (acc.size() !== 3 || acc[0] !== 0 || acc[1] !== 100 || acc[2] !== 120) begin
            failures++; $display("FAIL multi_accept: got n=%0d want 3 at 0,100,120", acc.size());
        end
        d = tx_diff(1, l);
        checks++; if (d != -1) begin failures++; $display("FAIL multi_wave: cycle %0d got %b want %b", d, lt(1 + d), exp_q[d]); end
        checks++; if (bad_en(1, l, 1'b1) != 0) begin failures++; $display("FAIL multi_en: got %0d low cycles want 0", bad_en(1, l, 1'b1)); end
        c = crc_upd(crc_upd(crc_upd(16'hFFFF, 8'hA5), 8'h3C), 8'hFF);
        for (int j = 0; j < 8; j++) begin
            got[j]     = lt(143 + 2 * j);
            got[j + 8] = lt(163 + 2 * j);
        end
        checks++; if (got !== c) begin failures++; $display("FAIL multi_crc: got %h want %h", got, c); end
        checks++; if (ld(l + 1) !== 1'b1 || count_done() != 1) begin failures++; $display("FAIL multi_done: got %b (n=%0d) want 1 (n=1)", ld(l + 1), count_done()); end
    endtask

    task automatic test_gap();
        int d, l;
        pay_q.delete(); pay_q.push_back(8'h12); pay_q.push_back(8'h34);
        prep(16'd9, 16'd1);
        src_q[1].dly = 106;
        repeat (7) exp_q.insert(100, 1'b1);
        run_done(600);
        l = exp_q.size();
        checks++; if (acc.size() !== 2 || acc[1] !== 107) begin failures++; $display("FAIL gap_accept: got n=%0d second at %0d want 2 at 107", acc.size(), acc.size() > 1 ? acc[1] : -1); end
        d = tx_diff(1, l);
        checks++; if (d != -1) begin failures++; $display("FAIL gap_wave: cycle %0d got %b want %b", d, lt(1 + d), exp_q[d]); end
        checks++; if (bad_en(1, l, 1'b1) != 0) begin failures++; $display("FAIL gap_en: got %0d low cycles want 0", bad_en(1, l, 1'b1)); end
        checks++; if (ld(l + 1) !== 1'b1) begin failures++; $display("FAIL gap_done: got %b want 1", ld(l + 1)); end
    endtask

    task automatic test_abort();
        int d, l;
        abort = 1'b1; tx_permit = 1'b1; s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL abort_idle_rdy: got %b want 0", s_ready); end
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++; if (tx_en !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL abort_idle_noacc: got en=%b tx=%b want 0 1", tx_en, tx); end
        @(posedge clk); #1;
        pay_q.delete(); pay_q.push_back(8'h55); pay_q.push_back(8'h52); pay_q.push_back(8'h0F);
        prep(16'd9, 16'd1);
        while (log_tx.size() < 109) step();
        d = tx_diff(1, 108);
        checks++; if (d != -1) begin failures++; $display("FAIL abort_pre: cycle %0d got %b want %b", d, lt(1 + d), exp_q[d]); end
        abort = 1'b1;
        step();
        abort = 1'b0; tx_permit = 1'b0; src_q.delete(); hold = 0;
        step();
        checks++; if (lt(110) !== 1'b1) begin failures++; $display("FAIL abort_tx: got %b want 1", lt(110)); end
        checks++; if (le(110) !== 1'b0) begin failures++; $display("FAIL abort_en: got %b want 0", le(110)); end
        repeat (40) step();
        checks++; if (count_done() != 0 || bad_en(110, 41, 1'b0) != 0) begin
            failures++; $display("FAIL abort_quiet: got done=%0d en_high=%0d want 0 0", count_done(), bad_en(110, 41, 1'b0));
        end
        pay_q.delete(); pay_q.push_back(8'hC3);
        prep(16'd9, 16'd1);
        run_done(600);
        l = exp_q.size();
        d = tx_diff(1, l);
        checks++; if (acc.size() !== 1 || d != -1) begin failures++; $display("FAIL abort_restart: n=%0d cycle %0d got %b want %b", acc.size(), d, lt(1 + d), d >= 0 ? exp_q[d] : 1'b0); end
    endtask

    task automatic test_permit();
        int d, l, r, t;
        pay_q.delete(); pay_q.push_back(8'h81);
        prep(16'd4, 16'd2);
        tx_permit = 1'b0;
        repeat (20) step();
        r = 0; t = 0;
        for (int i = 0; i < 20; i++) begin
            if (log_rdy[i] !== 1'b0) r++;
            if (log_tx[i] !== 1'b1) t++;
        end
        checks++; if (r != 0) begin failures++; $display("FAIL permit_rdy: got %0d ready cycles want 0", r); end
        checks++; if (t != 0 || acc.size() != 0) begin failures++; $display("FAIL permit_idle: got %0d low tx, %0d accepts want 0 0", t, acc.size()); end
        tx_permit = 1'b1;
        step();
        tx_permit = 1'b0;
        checks++; if (acc.size() !== 1 || acc[0] !== 20) begin failures++; $display("FAIL permit_accept: got n=%0d want 1 at 20", acc.size()); end
        run_done(400);
        l = exp_q.size();
        checks++; if (lt(21) !== 1'b0) begin failures++; $display("FAIL permit_start: got %b want 0", lt(21)); end
        d = tx_diff(21, l);
        checks++; if (d != -1 || ld(21 + l) !== 1'b1) begin failures++; $display("FAIL permit_frame: cycle %0d done=%b want -1 1", d, ld(21 + l)); end
    endtask

    task automatic test_div0();
        int d, l;
        pay_q.delete(); pay_q.push_back(8'h3C); pay_q.push_back(8'hC3);
        prep(16'd0, 16'd0);
        run_done(300);
        l = exp_q.size();
        checks++; if (acc.size() !== 2 || acc[1] !== 10) begin failures++; $display("FAIL div0_accept: got n=%0d want 2 with second at 10", acc.size()); end
        d = tx_diff(1, l);
        checks++; if (d != -1) begin failures++; $display("FAIL div0_wave: cycle %0d got %b want %b", d, lt(1 + d), exp_q[d]); end
        checks++; if (ld(l + 1) !== 1'b1 || le(l + 1) !== 1'b0) begin failures++; $display("FAIL div0_done: got done=%b en=%b want 1 0", ld(l + 1), le(l + 1)); end
    endtask

    task automatic test_reset_mid();
        int d;
        pay_q.delete(); pay_q.push_back(8'h00);
        prep(16'd3, 16'd5);
        while (log_tx.size() < 51) step();
        d = tx_diff(1, 50);
        checks++; if (d != -1 || le(50) !== 1'b1) begin failures++; $display("FAIL rstmid_pre: cycle %0d en=%b want -1 1", d, le(50)); end
        reset = 1'b1;
        step();
        reset = 1'b0; tx_permit = 1'b0; src_q.delete();
        step();
        checks++; if (lt(52) !== 1'b1) begin failures++; $display("FAIL rstmid_tx: got %b want 1", lt(52)); end
        checks++; if (le(52) !== 1'b0) begin failures++; $display("FAIL rstmid_en: got %b want 0", le(52)); end
        checks++; if (ld(52) !== 1'b0 || log_rdy[52] !== 1'b0) begin failures++; $display("FAIL rstmid_done_rdy: got %b %b want 0 0", ld(52), log_rdy[52]); end
        repeat (30) step();
        checks++; if (count_done() != 0 || bad_en(52, 31, 1'b0) != 0) begin failures++; $display("FAIL rstmid_quiet: got done=%0d want 0", count_done()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_gap();
        test_abort();
        test_permit();
        test_div0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_ser.md
TX_SER -- requirements
Module: tx_ser

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: div_ls  input  16  low-speed bit period minus 1, in clk cycles.
REQ-004 SHALL have port: div_hs  input  16  high-speed bit period minus 1, in clk cycles.
REQ-005 SHALL have port: tx_permit  input  1  bus granted; a frame may start only while high.
REQ-006 SHALL have port: abort  input  1  immediate frame termination.
REQ-007 SHALL have port: s_data  input  8  payload byte.
REQ-008 SHALL have port: s_valid  input  1  s_data valid.
REQ-009 SHALL have port: s_last  input  1  byte is the last payload byte of the frame.
REQ-010 SHALL have port: s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-011 SHALL have port: tx  output  1  serial line, idle high.
REQ-012 SHALL have port: tx_en  output  1  line-driver enable, high for the whole frame.
REQ-013 SHALL have port: frame_done  output  1  one-cycle pulse after the last stop bit completes.

Function
REQ-014 SHALL implement FSM IDLE, START, BITS, STOP (one-hot); only STOP returns to IDLE or START.
REQ-015 SHALL assert s_ready for one cycle: in IDLE when tx_permit=1, and in the final cycle of STOP when the current byte is a non-last payload byte.
REQ-016 SHALL go from IDLE to START on acceptance, with tx=0 and tx_en=1 on the next cycle.
REQ-017 SHALL hold each bit for div+1 clk cycles; bit counter 0..div, then the next bit; div is sampled at each bit start.
REQ-018 SHALL send per byte: start bit 0, 8 data bits LSB first, stop bit 1 (10 bits total).
REQ-019 SHALL use div_ls for every bit of the first byte of a frame and div_hs for all following bytes, including CRC bytes.
REQ-020 SHALL feed each payload data bit, at its bit start, into the CRC (clear at frame start).
REQ-021 SHALL, after the stop bit of the s_last byte, send crc_out[7:0] then crc_out[15:8] as normal bytes, with no CRC update.
REQ-022 SHALL keep the frame gapless: if the next payload byte is not valid at the final STOP cycle, it SHALL keep tx=1 in STOP until s_valid; the gap uses the current bit rate.
REQ-023 SHALL, after the CRC high byte's stop bit, pulse frame_done, drop tx_en, and enter IDLE.
REQ-024 SHALL, on abort in any state, enter IDLE next cycle with tx=1 and tx_en=0, without frame_done and without accepting a byte that cycle; the next frame restarts at low speed.
REQ-025 SHALL ignore tx_permit once a frame has started, and ignore s_valid while not ready.
REQ-026 SHALL accept a single-byte frame (s_last on the first byte): one low-speed byte, then two high-speed CRC bytes.
REQ-027 SHALL treat div=0 as a 1-cycle bit with no counter wrap error.

Reset
REQ-028 SHALL on reset: state=IDLE, tx=1, tx_en=0, s_ready=0, frame_done=0, bit/div counters=0, high-speed flag=0, CRC cleared.
REQ-029 SHALL give reset priority over abort and all other inputs.

Structure
REQ-030 SHALL put the FSM state encodings and the frame constants (bits per byte=10, CRC bytes=2) in the shared cdbus package.
REQ-031 SHALL instantiate the existing serial_crc as the only sub-module (clean at frame start, data_clk per payload bit).
REQ-032 SHALL register tx and tx_en directly from flops (no combinational path to pins).

Verification
REQ-033 SHALL check: div_ls=9, single-byte frame 0x01 -> tx=0,1,0,0,0,0,0,0,0,1, each bit 10 clk, then 2 CRC bytes at div_hs.
REQ-034 SHALL check: div_ls=9, div_hs=1, 3-byte frame 0xA5,0x3C,0xFF with s_valid held -> byte 1 at 10 clk/bit, rest at 2 clk/bit, no idle gap, CRC matches the model for those bytes.
REQ-035 SHALL check: s_valid deasserted for 7 cycles between bytes 1 and 2 -> tx stays 1, tx_en stays 1, byte 2 starts on the cycle after acceptance.
REQ-036 SHALL check: abort mid-bit 4 of byte 2 -> next cycle tx=1, tx_en=0, no frame_done; the next frame's first byte is at div_ls.
REQ-037 SHALL check: tx_permit=0 with s_valid=1 for 20 cycles -> s_ready=0, tx=1; when tx_permit rises, acceptance occurs and tx=0 on the following cycle.
REQ-038 SHALL check: reset asserted during CRC byte -> all outputs take reset values on the next cycle.
